// File: rtl/telegraph_pkg.sv
// Constants and types shared by the telegraph transmit and receive sides:
// preamble pattern, default payload length and the frame state encoding.
package telegraph_pkg;

  localparam int PREAMBLE_LEN = 4;
  localparam logic [PREAMBLE_LEN-1:0] PREAMBLE = 4'b1011;
  localparam int DEF_PAYLOAD_LEN = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } tx_state_e;

  // Preamble bit at position pos, counted from the first (MSB) bit sent.
  function automatic logic preamble_bit(input logic [31:0] pos);
    logic bit_s;
    case (pos)
      32'd0:   bit_s = PREAMBLE[3];
      32'd1:   bit_s = PREAMBLE[2];
      32'd2:   bit_s = PREAMBLE[1];
      32'd3:   bit_s = PREAMBLE[0];
      default: bit_s = 1'b0;
    endcase
    return bit_s;
  endfunction

endpackage

// File: rtl/telegraph_bit_cnt.sv
// Bit-period counter: synchronous clear, count enable, and a saturating
// terminal-count compare so the count never wraps inside one state.
module telegraph_bit_cnt #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc  = (cnt_q == term);
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/telegraph_tx.sv
// Telegraph frame transmitter: preamble, MSB-first payload, then an idle-low
// gap, advancing one bit per ClkEn strobe. All outputs come straight from flops.
module telegraph_tx
  import telegraph_pkg::*;
#(
  parameter int PAYLOAD_LEN = DEF_PAYLOAD_LEN,
  parameter int GAP_LEN     = 1
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   ClkEn,
  input  logic                   Start,
  input  logic [PAYLOAD_LEN-1:0] DataIn,
  output logic                   Ready,
  output logic                   SerOut,
  output logic                   SerOutValid,
  output logic                   Done
);

  localparam int CNT_MAX = (PAYLOAD_LEN > PREAMBLE_LEN) ? PAYLOAD_LEN : PREAMBLE_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] TERM_PRE  = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] TERM_DATA = CNT_W'(PAYLOAD_LEN - 1);
  localparam logic [CNT_W-1:0] TERM_GAP  = CNT_W'(GAP_LEN - 1);

  tx_state_e              state_q, state_d;
  logic [PAYLOAD_LEN-1:0] shift_q, shift_d;
  logic                   ser_out_q, ser_out_d;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;
  logic                   ready_q, ready_d;

  logic [CNT_W-1:0]       cnt_s;
  logic [CNT_W-1:0]       cnt_term_s;
  logic                   cnt_tc_s;
  logic                   cnt_en_s;
  logic                   cnt_clr_s;
  logic [PAYLOAD_LEN-1:0] shifted_s;
  logic                   pre_next_s;

  telegraph_bit_cnt #(
    .CNT_W(CNT_W)
  ) u_bit_cnt (
    .clk  (Clk),
    .rst_n(Rst),
    .en   (cnt_en_s),
    .clr  (cnt_clr_s),
    .term (cnt_term_s),
    .cnt  (cnt_s),
    .tc   (cnt_tc_s)
  );

  assign cnt_en_s   = ClkEn && (state_q != ST_IDLE);
  assign shifted_s  = shift_q << 1;
  assign pre_next_s = preamble_bit(32'(cnt_s) + 32'd1);

  always_comb begin
    case (state_q)
      ST_IDLE: cnt_term_s = '0;
      ST_PRE:  cnt_term_s = TERM_PRE;
      ST_DATA: cnt_term_s = TERM_DATA;
      ST_GAP:  cnt_term_s = TERM_GAP;
      default: cnt_term_s = '0;
    endcase
  end

  // Next-state and next-output values are computed together so each output
  // flop already holds the bit belonging to the state it is entering.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    ser_out_d = ser_out_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    cnt_clr_s = 1'b0;
    if (ClkEn) begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            state_d   = ST_PRE;
            shift_d   = DataIn;
            ser_out_d = preamble_bit(32'd0);
            valid_d   = 1'b0;
            cnt_clr_s = 1'b1;
          end else begin
            ser_out_d = 1'b0;
            valid_d   = 1'b0;
          end
        end
        ST_PRE: begin
          if (cnt_tc_s) begin
            state_d   = ST_DATA;
            ser_out_d = shift_q[PAYLOAD_LEN-1];
            valid_d   = 1'b1;
            cnt_clr_s = 1'b1;
          end else begin
            ser_out_d = pre_next_s;
            valid_d   = 1'b0;
          end
        end
        ST_DATA: begin
          if (cnt_tc_s) begin
            state_d   = ST_GAP;
            ser_out_d = 1'b0;
            valid_d   = 1'b0;
            cnt_clr_s = 1'b1;
          end else begin
            shift_d   = shifted_s;
            ser_out_d = shifted_s[PAYLOAD_LEN-1];
            valid_d   = 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_tc_s) begin
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            cnt_clr_s = 1'b1;
          end else begin
            state_d   = ST_GAP;
          end
          ser_out_d = 1'b0;
          valid_d   = 1'b0;
        end
        default: begin
          state_d   = ST_IDLE;
          ser_out_d = 1'b0;
          valid_d   = 1'b0;
          cnt_clr_s = 1'b1;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      ser_out_q <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      ser_out_q <= ser_out_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign Ready       = ready_q;
  assign SerOut      = ser_out_q;
  assign SerOutValid = valid_q;
  assign Done        = done_q;

endmodule

// File: tb/tb_telegraph_tx.sv
// Scoreboard bench for telegraph_tx: each accepted frame pushes its expected
// per-bit-period outputs, which are popped and compared on every ClkEn edge.
module tb_telegraph_tx;
  import telegraph_pkg::*;

  localparam int L   = 11;
  localparam int GAP = 1;
  localparam logic [3:0] EXP_IDLE = 4'b0001;  // {SerOut, SerOutValid, Done, Ready}

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         ClkEn = 1'b0;
  logic         Start = 1'b0;
  logic [L-1:0] DataIn = '0;
  logic         Ready, SerOut, SerOutValid, Done;

  int         n_tests = 0;
  int         n_fail = 0;
  int         n_acc = 0;
  int         cyc = 0;
  int         rx_cnt = 0;
  logic [31:0] rx = '0;
  logic [3:0] sb_q[$];
  logic [3:0] last_exp = EXP_IDLE;
  int         done_cyc[$];

  telegraph_tx #(.PAYLOAD_LEN(L), .GAP_LEN(GAP)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .ClkEn      (ClkEn),
    .Start      (Start),
    .DataIn     (DataIn),
    .Ready      (Ready),
    .SerOut     (SerOut),
    .SerOutValid(SerOutValid),
    .Done       (Done)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [L-1:0] d);
    logic [3:0] pre;
    pre = PREAMBLE;
    for (int i = PREAMBLE_LEN - 1; i >= 0; i--) sb_q.push_back({pre[i], 3'b000});
    for (int i = L - 1; i >= 0; i--) sb_q.push_back({d[i], 3'b100});
    for (int g = 0; g < GAP; g++) sb_q.push_back(4'b0000);
    sb_q.push_back(4'b0011);
  endtask

  task automatic cycle(input logic en, input string tag);
    logic [3:0] e;
    ClkEn = en;
    @(posedge Clk);
    cyc++;
    if (en) begin
      if (sb_q.size() == 0 && Start && Rst) begin
        push_frame(DataIn);
        n_acc++;
      end
      if (sb_q.size() != 0) e = sb_q.pop_front();
      else e = EXP_IDLE;
      last_exp = e;
    end else begin
      e = {last_exp[3:2], 1'b0, last_exp[0]};
    end
    #1;
    check_eq(tag, {28'd0, SerOut, SerOutValid, Done, Ready}, {28'd0, e});
    if (en && SerOutValid) begin
      rx = {rx[30:0], SerOut};
      rx_cnt++;
    end
    if (Done) done_cyc.push_back(cyc);
  endtask

  task automatic clear_rx();
    rx = '0;
    rx_cnt = 0;
    n_acc = 0;
    done_cyc.delete();
  endtask

  initial begin
    #1 Rst = 1'b0;
    #1 check_eq("reset_state", {28'd0, SerOut, SerOutValid, Done, Ready}, {28'd0, EXP_IDLE});
    cycle(1'b1, "reset_hold");
    @(negedge Clk) Rst = 1'b1;

    // Continuous enable, single frame
    clear_rx();
    DataIn = 11'h5A3;
    Start  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cycle(1'b1, "f1_bit");
      if (n_acc == 1) Start = 1'b0;
    end
    check_eq("f1_payload", rx & 32'h7FF, 32'h5A3);
    check_eq("f1_nbits", rx_cnt, 11);
    check_eq("f1_done_cyc", (done_cyc.size() == 1) ? done_cyc[0] : -1, 18);

    // Enable every 4th cycle
    clear_rx();
    DataIn = 11'h5A3;
    Start  = 1'b1;
    for (int c = 0; c < 17 * 4 + 8; c++) begin
      cycle((c % 4) == 3, "f4_bit");
      if (n_acc == 1) Start = 1'b0;
    end
    check_eq("f4_payload", rx & 32'h7FF, 32'h5A3);
    check_eq("f4_nbits", rx_cnt, 11);
    check_eq("f4_ndone", done_cyc.size(), 1);

    // Start held high across two frames
    clear_rx();
    DataIn = 11'h7FF;
    Start  = 1'b1;
    for (int c = 0; c < 60; c++) begin
      cycle(1'b1, "b2b_bit");
      if (n_acc >= 1) DataIn = 11'h000;
      if (n_acc >= 2) Start = 1'b0;
      if (n_acc >= 2 && sb_q.size() == 0) break;
    end
    repeat (3) cycle(1'b1, "b2b_idle");
    check_eq("b2b_payload", rx & 32'h3F_FFFF, {10'd0, 11'h7FF, 11'h000});
    check_eq("b2b_nbits", rx_cnt, 22);
    check_eq("b2b_ndone", done_cyc.size(), 2);
    check_eq("b2b_spacing", (done_cyc.size() == 2) ? done_cyc[1] - done_cyc[0] : -1, 17);

    // Reset mid-DATA after payload bit 5
    clear_rx();
    DataIn = 11'h5A3;
    Start  = 1'b1;
    cycle(1'b1, "mr_bit");
    Start = 1'b0;
    repeat (9) cycle(1'b1, "mr_bit");
    #2 Rst = 1'b0;
    #1 check_eq("mr_async", {28'd0, SerOut, SerOutValid, Done, Ready}, {28'd0, EXP_IDLE});
    sb_q.delete();
    last_exp = EXP_IDLE;
    repeat (2) cycle(1'b1, "mr_next");
    check_eq("mr_no_done", done_cyc.size(), 0);
    @(negedge Clk) Rst = 1'b1;
    clear_rx();
    DataIn = 11'h2C5;
    Start  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cycle(1'b1, "mr_frame");
      if (n_acc == 1) Start = 1'b0;
    end
    check_eq("mr_payload", rx & 32'h7FF, 32'h2C5);
    check_eq("mr_nbits", rx_cnt, 11);
    check_eq("mr_ndone", done_cyc.size(), 1);

    // Start pulse while ClkEn is low is ignored
    clear_rx();
    Start = 1'b1;
    cycle(1'b0, "noacc_pulse");
    Start = 1'b0;
    repeat (4) cycle(1'b1, "noacc_idle");
    check_eq("noacc_nbits", rx_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/telegraph_tx.md
TELEGRAPH_TX -- requirements
Module: telegraph_tx

Interface
REQ-001 The block SHALL have parameter PAYLOAD_LEN, default 11, giving payload bits per frame.
REQ-002 The block SHALL have parameter GAP_LEN, default 1, giving idle-low bit periods after each frame (minimum 1).
REQ-003 The block SHALL have port Clk, input, 1, the single clock.
REQ-004 The block SHALL have port Rst, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port ClkEn, input, 1, the bit-rate enable; each ClkEn=1 edge is one bit period.
REQ-006 The block SHALL have port Start, input, 1, the frame request (valid).
REQ-007 The block SHALL have port DataIn, input, PAYLOAD_LEN, the payload, sent MSB first.
REQ-008 The block SHALL have port Ready, output, 1; it is high only in IDLE.
REQ-009 The block SHALL have port SerOut, output, 1, the serial line.
REQ-010 The block SHALL have port SerOutValid, output, 1; it is high while a payload bit is on SerOut.
REQ-011 The block SHALL have port Done, output, 1, a one-Clk pulse at frame end.

Function
REQ-012 The FSM SHALL have states IDLE, PRE, DATA and GAP, and SHALL advance only on Clk edges with ClkEn=1.
REQ-013 A frame SHALL be accepted on a Clk edge where ClkEn=1, Ready=1 and Start=1; DataIn is then captured into a PAYLOAD_LEN shift register and the FSM goes to PRE.
REQ-014 Start and DataIn SHALL be held stable by the source until accepted; Start while Ready=0 or ClkEn=0 SHALL be ignored.
REQ-015 In PRE, SerOut SHALL carry the preamble 1,0,1,1 (PREAMBLE=4'b1011, MSB first), one bit per ClkEn edge; the first bit is visible immediately after the accept edge.
REQ-016 After 4 preamble bits the FSM SHALL enter DATA and drive DataIn[PAYLOAD_LEN-1] down to DataIn[0], one bit per ClkEn edge, with SerOutValid=1.
REQ-017 After the last payload bit the FSM SHALL enter GAP, with SerOut=0 and SerOutValid=0, for GAP_LEN bit periods.
REQ-018 At the end of GAP the FSM SHALL enter IDLE; Done=1 for exactly one Clk cycle on entry and Ready=1 from then on.
REQ-019 In IDLE, SerOut SHALL be 0 and SerOutValid SHALL be 0.
REQ-020 The bit counter SHALL be ceil(log2(max(PAYLOAD_LEN,4)))+1 bits wide, SHALL be cleared on every state entry, and SHALL never wrap within a state.
REQ-021 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-022 If ClkEn stays low, all state, counter, shift register and outputs SHALL hold; Done SHALL still deassert after one Clk.
REQ-023 Frame length SHALL be 4+PAYLOAD_LEN+GAP_LEN ClkEn periods; back-to-back frames are accepted on the first ClkEn edge in IDLE.

Reset
REQ-024 When Rst=0, the block SHALL immediately reset to state IDLE, counter 0, shift register 0, SerOut=0, SerOutValid=0, Done=0 and Ready=1, including mid-frame.
REQ-025 The frame in progress at reset SHALL be discarded, and no Done pulse SHALL be generated for it.

Structure
REQ-026 A shared package telegraph_pkg SHALL hold PREAMBLE, PREAMBLE_LEN=4, the default PAYLOAD_LEN and the state enum typedef, for reuse by the receive side.
REQ-027 The bit counter with enable, clear and terminal-count compare SHALL be one sub-module, telegraph_bit_cnt.

Verification
REQ-028 Reset, then ClkEn=1 every cycle, DataIn=11'h5A3 and Start=1: SerOut SHALL read 1,0,1,1, then 1,0,1,1,0,1,0,0,0,1,1 with SerOutValid=1 only for these 11 bits, then 0; Done SHALL pulse at bit 16.
REQ-029 With ClkEn=1 every 4th cycle: the same frame SHALL result, with each bit held exactly 4 Clk cycles and Done high for 1 Clk.
REQ-030 With Start held high continuously and DataIn=11'h7FF then 11'h000: two frames SHALL occur, separated by exactly 1 low gap bit, and Start during busy SHALL have no effect.
REQ-031 Rst=0 asserted mid-DATA (after payload bit 5): the next Clk SHALL show SerOut=0, Ready=1, no Done, and a new Start SHALL produce a full clean frame.
REQ-032 Start pulsed for one cycle with ClkEn=0: the block SHALL not be accepted and SHALL stay in IDLE with SerOut=0.
